// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller that sits on the feedback side of the ID/EX
// register. It compares the instruction in ID (IF/ID outputs) against the one
// in EX (ID/EX outputs). It inserts load-use stall bubbles and squashes
// wrong-path instructions after a taken branch.
//
// Optional feature macro: HAZARD_STATS_EN
//   defined   -> stall_count / flush_count statistics counters are built
//   undefined -> both counters are tied to zero and no counter flops exist
//
// Parameters
//   LOAD_BUBBLES  bubbles inserted per load-use hazard (1..7)
//   FLUSH_CYCLES  cycles IFID_Flush/IDEX_Bubble are held after a taken branch (1..7)
//   CNT_W         width of the statistics counters
//
// Ports
//   clk           clock, all state changes on the rising edge
//   reset         asynchronous, active-low reset
//   IFID_rs1/rs2  source register fields of the instruction in ID
//   IFID_use_rs1  ID instruction reads rs1
//   IFID_use_rs2  ID instruction reads rs2
//   IDEX_rd       destination register of the instruction in EX
//   IDEX_MemRead  EX instruction is a load
//   branch_taken  branch resolved taken this cycle
//   PC_Write      1 = PC may update
//   IFID_Write    1 = IF/ID may load
//   IFID_Flush    1 = IF/ID loads a NOP
//   IDEX_Bubble   1 = ID/EX control inputs forced to zero
//   stall_count   load-use bubbles inserted (HAZARD_STATS_EN only)
//   flush_count   taken-branch flush events (HAZARD_STATS_EN only)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int LOAD_BUBBLES = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IFID_rs1,
  input  logic [4:0]       IFID_rs2,
  input  logic             IFID_use_rs1,
  input  logic             IFID_use_rs2,
  input  logic [4:0]       IDEX_rd,
  input  logic             IDEX_MemRead,
  input  logic             branch_taken,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // The remaining-cycle counter is only 3 bits, so both lengths must fit 1..7.
  if (LOAD_BUBBLES < 1 || LOAD_BUBBLES > 7) begin : g_bad_load_bubbles
    $error("hazard_ctrl: LOAD_BUBBLES must be in 1..7");
  end
  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
    $error("hazard_ctrl: FLUSH_CYCLES must be in 1..7");
  end

  // The cycle that detects the hazard is itself the first bubble, so the
  // follow-on state only has to cover the remaining N-1 cycles.
  localparam logic [2:0] STALL_INIT = 3'(LOAD_BUBBLES - 1);
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       lu_hit;

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  // x0 is hard-wired to zero and can never cause a dependency.
  always_comb begin
    lu_hit = IDEX_MemRead && (IDEX_rd != 5'd0) &&
             ((IFID_use_rs1 && (IFID_rs1 == IDEX_rd)) ||
              (IFID_use_rs2 && (IFID_rs2 == IDEX_rd)));
  end

  // State and remaining-cycle counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and Mealy outputs. A taken branch in RUN or STALL always wins
  // (it also aborts a stall in progress); once in FLUSH further branches are
  // from the wrong path and are ignored. A cnt of 1 marks the last cycle of a
  // STALL/FLUSH run; the cnt==0 guard only keeps the counter from wrapping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;

    unique case (state_q)
      ST_RUN, ST_STALL: begin
        if (branch_taken) begin
          IFID_Flush  = 1'b1;
          IDEX_Bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_INIT;
          end else begin
            state_d = ST_RUN;
            cnt_d   = 3'd0;
          end
        end else if (state_q == ST_STALL) begin
          PC_Write    = 1'b0;
          IFID_Write  = 1'b0;
          IDEX_Bubble = 1'b1;
          if (cnt_q <= 3'd1) begin
            state_d = ST_RUN;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end else if (lu_hit) begin
          PC_Write    = 1'b0;
          IFID_Write  = 1'b0;
          IDEX_Bubble = 1'b1;
          if (LOAD_BUBBLES > 1) begin
            state_d = ST_STALL;
            cnt_d   = STALL_INIT;
          end
        end
      end
      ST_FLUSH: begin
        IFID_Flush  = 1'b1;
        IDEX_Bubble = 1'b1;
        if (cnt_q <= 3'd1) begin
          state_d = ST_RUN;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 3'd0;
      end
    endcase

    // While reset is held the pipeline front end is frozen and fed bubbles.
    if (!reset) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic             stall_evt;
  logic             flush_evt;

  // A bubble counts as a stall only when it comes from a load-use hazard or
  // the STALL state and is not pre-empted by a taken branch in the same cycle.
  // A flush is counted once per branch accepted outside FLUSH.
  always_comb begin
    stall_evt     = !branch_taken &&
                    (((state_q == ST_RUN) && lu_hit) || (state_q == ST_STALL));
    flush_evt     = branch_taken && (state_q != ST_FLUSH);
    stall_count_d = stall_count_q + (stall_evt ? CNT_W'(1) : CNT_W'(0));
    flush_count_d = flush_count_q + (flush_evt ? CNT_W'(1) : CNT_W'(0));
  end

  // Statistics counters; they wrap naturally modulo 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule
